// File: rtl/uart_frame_packetizer.sv
// Frame builder feeding uart_tx one byte at a time: HEADER, SEQ, payload (MSB first), optional CHECKSUM.
// Define FRAME_CHECKSUM_EN to append the XOR checksum byte (SEQ ^ payload bytes).
module uart_frame_packetizer #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS  = 8192
) (
  input  logic                         i_Clock,
  input  logic                         i_rst,
  input  logic                         i_Valid,
  input  logic [8*PAYLOAD_BYTES-1:0]   i_Payload,
  output logic                         o_Ready,
  output logic                         o_Tx_DV,
  output logic [7:0]                   o_Tx_Byte,
  input  logic                         i_Tx_Done,
  output logic                         o_Busy,
  output logic                         o_Frame_Done,
  output logic                         o_Timeout,
  output logic [7:0]                   o_Seq
);

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 3;
`else
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 2;
`endif
  localparam int unsigned IDX_W = $clog2(FRAME_BYTES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  // Abort decision is taken one clock early so o_Timeout lands TIMEOUT_CLKS after the strobe
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CLKS - 2);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t                       state, state_next;
  logic [IDX_W-1:0]             idx, idx_next;
  logic [CNT_W-1:0]             cnt;
  logic                         done_d;
  logic                         done_edge;
  logic                         accept;
  logic                         frame_done_next;
  logic                         timeout_next;
  logic [8*PAYLOAD_BYTES-1:0]   payload_q;
  logic [7:0]                   seq_q;
  logic [7:0]                   frame_byte;

  assign done_edge = i_Tx_Done & ~done_d;
  assign accept    = i_Valid & o_Ready;
  assign o_Busy    = (state != S_IDLE);
  assign o_Tx_DV   = (state == S_SEND);
  assign o_Tx_Byte = (state == S_SEND) ? frame_byte : '0;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] checksum;
  always_comb begin
    checksum = seq_q;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++)
      checksum = checksum ^ payload_q[8*i +: 8];
  end
`endif

  always_comb begin
    frame_byte = HEADER_BYTE;
    if (idx == IDX_W'(1))
      frame_byte = seq_q;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++)
      if (idx == IDX_W'(i + 2))
        frame_byte = payload_q[8*(PAYLOAD_BYTES-i)-1 -: 8];
`ifdef FRAME_CHECKSUM_EN
    if (idx == LAST_IDX)
      frame_byte = checksum;
`endif
  end

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    frame_done_next = 1'b0;
    timeout_next    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_SEND;
          idx_next   = '0;
        end
      end
      S_SEND: state_next = S_WAIT;
      S_WAIT: begin
        if (done_edge) begin
          if (idx == LAST_IDX) begin
            state_next      = S_IDLE;
            frame_done_next = 1'b1;
          end else begin
            state_next = S_SEND;
            idx_next   = idx + IDX_W'(1);
          end
        end else if (cnt == CNT_LIMIT) begin
          state_next   = S_IDLE;
          timeout_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      done_d       <= 1'b0;
      o_Ready      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Timeout    <= 1'b0;
      o_Seq        <= '0;
      payload_q    <= '0;
      seq_q        <= '0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      done_d       <= i_Tx_Done;
      o_Ready      <= (state_next == S_IDLE);
      o_Frame_Done <= frame_done_next;
      o_Timeout    <= timeout_next;
      if (frame_done_next)
        o_Seq <= o_Seq + 8'd1;
      if (accept) begin
        payload_q <= i_Payload;
        seq_q     <= o_Seq;
      end
      if (state == S_SEND)
        cnt <= '0;
      else if (state == S_WAIT)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_frame_packetizer.sv
// Directed bench for uart_frame_packetizer with a behavioural uart_tx stand-in (configurable done latency).
module tb_uart_frame_packetizer;
`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic        i_Clock = 1'b0;
  logic        i_rst   = 1'b1;
  logic        i_Valid = 1'b0;
  logic [31:0] i_Payload = '0;
  logic        i_Tx_Done;
  logic        o_Ready, o_Tx_DV, o_Busy, o_Frame_Done, o_Timeout;
  logic [7:0]  o_Tx_Byte, o_Seq;

  logic stub_done = 1'b0;
  logic inj_done  = 1'b0;
  logic stub_en   = 1'b1;
  int   stub_cnt  = 0;
  int   stub_lat  = 40;

  int errors = 0;
  int checks = 0;

  logic [7:0] txq[$];
  int   dv_double = 0;
  logic dv_prev = 1'b0;

  assign i_Tx_Done = stub_done | inj_done;

  uart_frame_packetizer #(
    .PAYLOAD_BYTES(4),
    .HEADER_BYTE(8'hA5),
    .TIMEOUT_CLKS(100)
  ) dut (
    .i_Clock(i_Clock), .i_rst(i_rst), .i_Valid(i_Valid), .i_Payload(i_Payload),
    .o_Ready(o_Ready), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Done(i_Tx_Done),
    .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Timeout(o_Timeout), .o_Seq(o_Seq)
  );

  always #5 i_Clock = ~i_Clock;

  // uart_tx stand-in: done goes high for two clocks, stub_lat clocks after each strobe
  always @(posedge i_Clock) begin
    if (i_rst) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else begin
      if (o_Tx_DV && stub_en) stub_cnt <= stub_lat;
      else if (stub_cnt > 0)  stub_cnt <= stub_cnt - 1;
      stub_done <= (stub_cnt == 1) || (stub_cnt == 2);
    end
  end

  always @(posedge i_Clock) begin
    if (o_Tx_DV) txq.push_back(o_Tx_Byte);
    if (o_Tx_DV && dv_prev) dv_double <= dv_double + 1;
    dv_prev <= o_Tx_DV;
  end

  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] p, input logic [7:0] s, input int i);
    case (i)
      0:       return 8'hA5;
      1:       return s;
      2:       return p[31:24];
      3:       return p[23:16];
      4:       return p[15:8];
      5:       return p[7:0];
      default: return s ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endcase
  endfunction

  task automatic test_reset;
    i_rst = 1'b1; i_Valid = 1'b0;
    tick; tick;
    checks++; if (o_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", o_Ready); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
    checks++; if (o_Tx_DV !== 1'b0 || o_Tx_Byte !== 8'h00) begin errors++; $display("FAIL reset_tx: got dv=%b byte=%h expected 0/00", o_Tx_DV, o_Tx_Byte); end
    checks++; if (o_Frame_Done !== 1'b0 || o_Timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fd=%b to=%b expected 0/0", o_Frame_Done, o_Timeout); end
    checks++; if (o_Seq !== 8'h00) begin errors++; $display("FAIL reset_seq: got %h expected 00", o_Seq); end
    i_rst = 1'b0;
    tick;
    checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", o_Ready); end
  endtask

  task automatic test_single_frame;
    logic [7:0] exp1 [7];
    int n;
    exp1 = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    txq.delete();
    i_Payload = 32'h11223344; i_Valid = 1'b1;
    tick;
    i_Valid = 1'b0;
    checks++; if (o_Tx_DV !== 1'b1 || o_Tx_Byte !== 8'hA5) begin errors++; $display("FAIL single_header_latency: got dv=%b byte=%h expected 1/a5", o_Tx_DV, o_Tx_Byte); end
    n = 0;
    while (o_Frame_Done !== 1'b1 && n < 2000) begin tick; n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL single_done_wait: got no frame_done in %0d cycles expected one", n); end
    checks++; if (o_Ready !== 1'b1 || o_Seq !== 8'h01) begin errors++; $display("FAIL single_done_state: got ready=%b seq=%h expected 1/01", o_Ready, o_Seq); end
    tick;
    checks++; if (o_Frame_Done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", o_Frame_Done); end
    checks++; if (txq.size() != FLEN) begin errors++; $display("FAIL single_len: got %0d expected %0d", txq.size(), FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== exp1[i]) begin
        errors++; $display("FAIL single_byte%0d: got %h expected %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp1[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nf, n, bad, dv_base;
    i_rst = 1'b1; tick; i_rst = 1'b0; tick;
    stub_lat = 12;
    txq.delete();
    dv_base = dv_double;
    i_Payload = 32'hDEADBEEF; i_Valid = 1'b1;
    nf = 0; n = 0;
    while (nf < 257 && n < 60000) begin
      tick; n++;
      if (o_Frame_Done === 1'b1) begin
        nf++;
        if (nf == 257) i_Valid = 1'b0;
      end
    end
    i_Valid = 1'b0;
    tick; tick;
    checks++; if (nf != 257) begin errors++; $display("FAIL b2b_frames: got %0d expected 257", nf); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL b2b_extra_frame: got busy=%b expected 0", o_Busy); end
    checks++; if (txq.size() != 257*FLEN) begin errors++; $display("FAIL b2b_bytes: got %0d expected %0d", txq.size(), 257*FLEN); end
    bad = 0;
    for (int f = 0; f < 257; f++)
      for (int i = 0; i < FLEN; i++)
        if (f*FLEN+i >= txq.size() || txq[f*FLEN+i] !== exp_byte(32'hDEADBEEF, 8'(f), i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_content: got %0d wrong bytes expected 0", bad); end
    checks++; if (dv_double != dv_base) begin errors++; $display("FAIL b2b_dv_double: got %0d expected %0d", dv_double, dv_base); end
    checks++; if (o_Seq !== 8'h01) begin errors++; $display("FAIL b2b_seq_wrap: got %h expected 01", o_Seq); end
    stub_lat = 40;
  endtask

  task automatic test_timeout;
    int cyc, nfd;
    i_rst = 1'b1; tick; i_rst = 1'b0; tick;
    stub_en = 1'b0;
    txq.delete();
    i_Payload = 32'h01020304; i_Valid = 1'b1;
    tick;
    i_Valid = 1'b0;
    checks++; if (o_Tx_DV !== 1'b1 || o_Tx_Byte !== 8'hA5) begin errors++; $display("FAIL to_header: got dv=%b byte=%h expected 1/a5", o_Tx_DV, o_Tx_Byte); end
    cyc = 0; nfd = 0;
    while (o_Timeout !== 1'b1 && cyc < 500) begin
      tick; cyc++;
      if (o_Frame_Done === 1'b1) nfd++;
    end
    checks++; if (cyc != 100) begin errors++; $display("FAIL to_latency: got %0d cycles expected 100", cyc); end
    checks++; if (o_Ready !== 1'b1 || o_Busy !== 1'b0) begin errors++; $display("FAIL to_ready: got ready=%b busy=%b expected 1/0", o_Ready, o_Busy); end
    checks++; if (o_Seq !== 8'h00) begin errors++; $display("FAIL to_seq: got %h expected 00", o_Seq); end
    checks++; if (nfd != 0) begin errors++; $display("FAIL to_no_frame_done: got %0d expected 0", nfd); end
    tick;
    checks++; if (o_Timeout !== 1'b0) begin errors++; $display("FAIL to_width: got %b expected 0", o_Timeout); end
    checks++; if (txq.size() != 1) begin errors++; $display("FAIL to_strobes: got %0d expected 1", txq.size()); end
    stub_en = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int n, strobes;
    i_Payload = 32'h55667788; i_Valid = 1'b1;
    tick;
    i_Valid = 1'b0;
    n = 0;
    while (o_Frame_Done !== 1'b1 && n < 2000) begin tick; n++; end
    tick;
    txq.delete();
    i_Valid = 1'b1;
    tick;
    i_Valid = 1'b0;
    strobes = 1; n = 0;
    while (strobes < 3 && n < 2000) begin
      tick; n++;
      if (o_Tx_DV === 1'b1) strobes++;
    end
    repeat (5) tick;
    checks++; if (o_Busy !== 1'b1 || o_Seq !== 8'h01) begin errors++; $display("FAIL mid_prereset: got busy=%b seq=%h expected 1/01", o_Busy, o_Seq); end
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    checks++; if (o_Busy !== 1'b0 || o_Tx_DV !== 1'b0 || o_Seq !== 8'h00) begin errors++; $display("FAIL mid_reset: got busy=%b dv=%b seq=%h expected 0/0/00", o_Busy, o_Tx_DV, o_Seq); end
    tick;
    txq.delete();
    i_Payload = 32'hCAFEF00D; i_Valid = 1'b1;
    tick;
    i_Valid = 1'b0;
    n = 0;
    while (o_Frame_Done !== 1'b1 && n < 2000) begin tick; n++; end
    tick;
    checks++; if (txq.size() < 2 || txq[0] !== 8'hA5 || txq[1] !== 8'h00) begin errors++; $display("FAIL mid_restart: got %0d bytes starting %h %h expected a5 00", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx); end
    checks++; if (txq.size() != FLEN || o_Seq !== 8'h01) begin errors++; $display("FAIL mid_restart_frame: got len=%0d seq=%h expected %0d/01", txq.size(), o_Seq, FLEN); end
  endtask

  task automatic test_done_idle;
    int nb, bad;
    nb = txq.size(); bad = 0;
    inj_done = 1'b1;
    tick;
    if (o_Tx_DV !== 1'b0 || o_Frame_Done !== 1'b0 || o_Ready !== 1'b1) bad++;
    tick;
    inj_done = 1'b0;
    repeat (8) begin
      if (o_Tx_DV !== 1'b0 || o_Frame_Done !== 1'b0 || o_Ready !== 1'b1) bad++;
      tick;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_done: got %0d bad cycles expected 0", bad); end
    checks++; if (txq.size() != nb) begin errors++; $display("FAIL idle_done_strobes: got %0d expected %0d", txq.size(), nb); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_timeout;
    test_reset_midframe;
    test_done_idle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
